pe_mac_pipe: RTL and testbench



---
 rtl/pe_mac_pipe.sv | 170 +++++++++++++++++
 tb/tb_pe_mac_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_pipe.sv
// Systolic multiply-accumulate processing element: forwards operands east/south and
// accumulates framed dot products with optional product pipelining and saturation.
module pe_mac_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 0,
    parameter int MULT_PIPE  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic [ACC_WIDTH-1:0]  res_o,
    output logic                  res_valid_o,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);
    // Framing: a beat is a cycle with valid_i=1; last_i is only meaningful on a beat.
    // There is no ready; every beat is consumed in the cycle it is presented.
    localparam int PW = 2*DATA_WIDTH;
    localparam int XW = ACC_WIDTH + 1 - PW;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [PW-1:0]        r_prod;
    logic                 r_pvalid;
    logic                 r_plast;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_sticky;

    logic [PW-1:0]        w_a_ext;
    logic [PW-1:0]        w_b_ext;
    logic [PW-1:0]        w_prod_now;
    logic [PW-1:0]        w_prod;
    logic                 w_beat;
    logic                 w_beat_last;
    logic [ACC_WIDTH:0]   w_prod_x;
    logic [ACC_WIDTH:0]   w_acc_x;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_sat;
    logic [ACC_WIDTH-1:0] w_next_acc;

    // Extending both operands to PW bits first makes the low PW bits of the product
    // correct for either signedness.
    assign w_a_ext    = {{DATA_WIDTH{(SIGNED != 0) && a_i[DATA_WIDTH-1]}}, a_i};
    assign w_b_ext    = {{DATA_WIDTH{(SIGNED != 0) && b_i[DATA_WIDTH-1]}}, b_i};
    assign w_prod_now = w_a_ext * w_b_ext;

    assign w_prod      = (MULT_PIPE != 0) ? r_prod   : w_prod_now;
    assign w_beat      = (MULT_PIPE != 0) ? r_pvalid : valid_i;
    assign w_beat_last = (MULT_PIPE != 0) ? r_plast  : (valid_i & last_i);

    assign w_prod_x = {{XW{(SIGNED != 0) && w_prod[PW-1]}}, w_prod};
    assign w_acc_x  = {(SIGNED != 0) && r_acc[ACC_WIDTH-1], r_acc};
    assign w_sum    = w_acc_x + w_prod_x;
    assign w_ovf    = (SIGNED != 0) ? (w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1]) : w_sum[ACC_WIDTH];

    // Bit ACC_WIDTH of the wide sum carries the true sign, selecting which rail to clamp to.
    always_comb begin
        w_sat = '1;
        if (SIGNED != 0) begin
            w_sat = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign w_next_acc = ((SATURATE != 0) && w_ovf) ? w_sat : w_sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_o         <= '0;
            b_o         <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            r_prod      <= '0;
            r_pvalid    <= 1'b0;
            r_plast     <= 1'b0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
        end else if (!start_i) begin
            a_o         <= '0;
            b_o         <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            r_prod      <= '0;
            r_pvalid    <= 1'b0;
            r_plast     <= 1'b0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
        end else begin
            valid_o     <= valid_i;
            last_o      <= valid_i & last_i;
            if (valid_i) begin
                a_o <= a_i;
                b_o <= b_i;
            end
            r_prod      <= w_prod_now;
            r_pvalid    <= valid_i;
            r_plast     <= valid_i & last_i;
            res_valid_o <= 1'b0;
            // Completion restarts the accumulator on the same edge so the next beat needs no bubble.
            if (w_beat) begin
                if (w_beat_last) begin
                    res_o       <= w_next_acc;
                    overflow_o  <= r_sticky | w_ovf;
                    res_valid_o <= 1'b1;
                    r_acc       <= '0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc    <= w_next_acc;
                    r_sticky <= r_sticky | w_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else if (!start_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FLUSH marks a registered last product still waiting for its final add.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid_i && !last_i)     w_state_nxt = S_ACCUM;
                else if (valid_i && last_i) w_state_nxt = (MULT_PIPE != 0) ? S_FLUSH : S_IDLE;
            end
            S_ACCUM: begin
                if (valid_i && last_i)      w_state_nxt = (MULT_PIPE != 0) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (valid_i && !last_i)     w_state_nxt = S_ACCUM;
                else if (valid_i && last_i) w_state_nxt = S_FLUSH;
                else                        w_state_nxt = S_IDLE;
            end
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (r_state != S_IDLE);
        state_o = r_state;
    end
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe: four differently configured PEs share one stimulus stream and are
// checked against an arithmetic dot-product model, a directed vector table and abort sequences.
module tb_pe_mac_pipe;
    logic       clk_i = 1'b0;
    logic       rst_ni, start_i, valid_i, last_i;
    logic [7:0] a_i, b_i;

    logic [7:0]  ao [4];
    logic [7:0]  bo [4];
    logic        vo [4];
    logic        lo [4];
    logic        rv [4];
    logic        ov [4];
    logic        bz [4];
    logic [1:0]  st [4];
    logic [19:0] res0;
    logic [15:0] res1, res2, res3;

    int p_acc  [4] = '{20, 16, 16, 16};
    bit p_sgn  [4] = '{1, 1, 1, 0};
    bit p_sat  [4] = '{0, 0, 1, 1};
    int p_pipe [4] = '{1, 0, 1, 0};

    always #5 clk_i = ~clk_i;

    pe_mac_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(0), .MULT_PIPE(1)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i), .last_i(last_i),
        .a_i(a_i), .b_i(b_i), .a_o(ao[0]), .b_o(bo[0]), .valid_o(vo[0]), .last_o(lo[0]),
        .res_o(res0), .res_valid_o(rv[0]), .overflow_o(ov[0]), .busy_o(bz[0]), .state_o(st[0]));
    pe_mac_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0), .MULT_PIPE(0)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i), .last_i(last_i),
        .a_i(a_i), .b_i(b_i), .a_o(ao[1]), .b_o(bo[1]), .valid_o(vo[1]), .last_o(lo[1]),
        .res_o(res1), .res_valid_o(rv[1]), .overflow_o(ov[1]), .busy_o(bz[1]), .state_o(st[1]));
    pe_mac_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1), .MULT_PIPE(1)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i), .last_i(last_i),
        .a_i(a_i), .b_i(b_i), .a_o(ao[2]), .b_o(bo[2]), .valid_o(vo[2]), .last_o(lo[2]),
        .res_o(res2), .res_valid_o(rv[2]), .overflow_o(ov[2]), .busy_o(bz[2]), .state_o(st[2]));
    pe_mac_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1), .MULT_PIPE(0)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i), .last_i(last_i),
        .a_i(a_i), .b_i(b_i), .a_o(ao[3]), .b_o(bo[3]), .valid_o(vo[3]), .last_o(lo[3]),
        .res_o(res3), .res_valid_o(rv[3]), .overflow_o(ov[3]), .busy_o(bz[3]), .state_o(st[3]));

    // Scoreboard and reference model state
    typedef struct { int inst; int due; longint res; bit ovf; } exp_t;
    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    longint m_acc [4];
    bit     m_stk [4];
    int     m_cnt [4];
    bit     e_val, e_last;
    logic [7:0] e_a, e_b;
    bit     e_rv  [4];
    longint e_res [4];
    bit     e_ovf [4];
    bit     e_busy[4];

    typedef struct { bit v; bit l; logic [7:0] a; logic [7:0] b; int ci; longint cres; bit covf; } vec_t;
    vec_t tbl[$];

    function automatic longint get_res(int i);
        case (i)
            0:       return longint'(res0);
            1:       return longint'(res1);
            2:       return longint'(res2);
            default: return longint'(res3);
        endcase
    endfunction

    function automatic longint mask(int i);
        return (longint'(1) << p_acc[i]) - 1;
    endfunction

    function automatic longint sx(logic [7:0] x, bit s);
        return (s && x[7]) ? longint'(x) - 256 : longint'(x);
    endfunction

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        e_val = 0; e_last = 0; e_a = '0; e_b = '0;
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0; m_stk[i] = 0; m_cnt[i] = 0;
            e_rv[i] = 0; e_res[i] = 0; e_ovf[i] = 0; e_busy[i] = 0;
        end
    endtask

    // One sampled edge: a dot product's value is plain integer arithmetic, clamped or wrapped
    // into the accumulator range; its result becomes visible pipe-depth edges after the last beat.
    task automatic model_update(input bit s, input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
        exp_t   keep[$];
        longint p, x, hi, lo_v;
        bit     o;
        cyc++;
        if (!s) begin
            model_clear();
            return;
        end
        e_val = v; e_last = v & l;
        if (v) begin e_a = a; e_b = b; end
        for (int i = 0; i < 4; i++) begin
            e_rv[i] = 0;
            if (v) begin
                p    = sx(a, p_sgn[i]) * sx(b, p_sgn[i]);
                hi   = p_sgn[i] ? (mask(i) >> 1) : mask(i);
                lo_v = p_sgn[i] ? -(hi + 1) : 0;
                x    = m_acc[i] + p;
                o    = (x > hi) || (x < lo_v);
                if (o && p_sat[i]) x = (x > hi) ? hi : lo_v;
                else if (o) begin
                    x = x & mask(i);
                    if (x > hi) x = x - (mask(i) + 1);
                end
                m_acc[i] = x;
                m_stk[i] = m_stk[i] | o;
                m_cnt[i]++;
                if (l) begin
                    exp_q.push_back('{inst: i, due: cyc + p_pipe[i], res: x, ovf: m_stk[i]});
                    m_acc[i] = 0; m_stk[i] = 0; m_cnt[i] = 0;
                end
            end
        end
        foreach (exp_q[k]) begin
            if (exp_q[k].due == cyc) begin
                e_rv[exp_q[k].inst]  = 1;
                e_res[exp_q[k].inst] = exp_q[k].res;
                e_ovf[exp_q[k].inst] = exp_q[k].ovf;
            end else begin
                keep.push_back(exp_q[k]);
            end
        end
        exp_q = keep;
        for (int i = 0; i < 4; i++) e_busy[i] = (m_cnt[i] > 0);
        foreach (exp_q[k]) e_busy[exp_q[k].inst] = 1;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid_o[%0d]", i), longint'(vo[i]), longint'(e_val));
            chk($sformatf("last_o[%0d]", i), longint'(lo[i]), longint'(e_last));
            chk($sformatf("a_o[%0d]", i), longint'(ao[i]), longint'(e_a));
            chk($sformatf("b_o[%0d]", i), longint'(bo[i]), longint'(e_b));
            chk($sformatf("res_valid_o[%0d]", i), longint'(rv[i]), longint'(e_rv[i]));
            chk($sformatf("res_o[%0d]", i), get_res(i), e_res[i] & mask(i));
            chk($sformatf("overflow_o[%0d]", i), longint'(ov[i]), longint'(e_ovf[i]));
            chk($sformatf("busy_o[%0d]", i), longint'(bz[i]), longint'(e_busy[i]));
        end
    endtask

    task automatic step(input bit s, input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
        start_i = s; valid_i = v; last_i = l; a_i = a; b_i = b;
        @(posedge clk_i);
        model_update(s, v, l, a, b);
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic add_vec(input bit v, input bit l, input logic [7:0] a, input logic [7:0] b,
                           input int ci, input longint cres, input bit covf);
        vec_t t;
        t.v = v; t.l = l; t.a = a; t.b = b; t.ci = ci; t.cres = cres; t.covf = covf;
        tbl.push_back(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; start_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; a_i = '0; b_i = '0;
        model_clear();
        repeat (2) @(negedge clk_i);
        compare_all();
        rst_ni = 1'b1;

        // Directed vectors: {valid, last, a, b, checked instance, result, overflow}
        add_vec(1, 0, 8'd3,   8'd4,   -1, 0, 0);
        add_vec(1, 0, 8'hFE,  8'd5,   -1, 0, 0);
        add_vec(1, 1, 8'd7,   8'hFF,   1, 16'hFFFB, 0);
        add_vec(0, 0, 8'd0,   8'd0,    0, 20'hFFFFB, 0);
        add_vec(1, 1, 8'd2,   8'd2,    1, 4, 0);
        add_vec(1, 0, 8'd1,   8'd1,   -1, 0, 0);
        add_vec(1, 1, 8'd1,   8'd1,    1, 2, 0);
        add_vec(0, 0, 8'd0,   8'd0,   -1, 0, 0);
        add_vec(1, 0, 8'd127, 8'd127, -1, 0, 0);
        add_vec(1, 0, 8'd127, 8'd127, -1, 0, 0);
        add_vec(1, 1, 8'd127, 8'd127,  1, 16'hBD03, 1);
        add_vec(0, 0, 8'd0,   8'd0,    2, 16'h7FFF, 1);
        add_vec(1, 1, 8'd1,   8'd1,    1, 1, 0);
        add_vec(0, 0, 8'd0,   8'd0,    2, 1, 0);
        add_vec(1, 0, 8'h80,  8'h80,  -1, 0, 0);
        add_vec(1, 1, 8'h80,  8'h80,   1, 16'h8000, 1);
        add_vec(0, 0, 8'd0,   8'd0,    2, 16'h7FFF, 1);
        add_vec(1, 1, 8'd255, 8'd255,  3, 65025, 0);
        add_vec(1, 0, 8'd1,   8'd255, -1, 0, 0);
        add_vec(0, 0, 8'd0,   8'd0,   -1, 0, 0);
        add_vec(0, 0, 8'd0,   8'd0,   -1, 0, 0);
        add_vec(0, 0, 8'd0,   8'd0,   -1, 0, 0);
        add_vec(1, 1, 8'd254, 8'd255,  3, 65025, 0);
        add_vec(1, 0, 8'd255, 8'd255, -1, 0, 0);
        add_vec(1, 1, 8'd255, 8'd255,  3, 16'hFFFF, 1);
        add_vec(0, 0, 8'd0,   8'd0,   -1, 0, 0);

        foreach (tbl[k]) begin
            step(1, tbl[k].v, tbl[k].l, tbl[k].a, tbl[k].b);
            if (tbl[k].ci >= 0) begin
                chk($sformatf("vec%0d res_valid", k), longint'(rv[tbl[k].ci]), 1);
                chk($sformatf("vec%0d res", k), get_res(tbl[k].ci), tbl[k].cres);
                chk($sformatf("vec%0d ovf", k), longint'(ov[tbl[k].ci]), longint'(tbl[k].covf));
            end
        end

        // Soft clear coincident with a last beat discards the dot product entirely.
        step(1, 1, 0, 8'd3, 8'd3);
        step(0, 1, 1, 8'd4, 8'd4);
        step(1, 0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort res_valid[%0d]", i), longint'(rv[i]), 0);
            chk($sformatf("abort res[%0d]", i), get_res(i), 0);
            chk($sformatf("abort busy[%0d]", i), longint'(bz[i]), 0);
        end

        // Asynchronous reset between edges.
        step(1, 1, 0, 8'd9, 8'd9);
        #3 rst_ni = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async a_o[%0d]", i), longint'(ao[i]), 0);
            chk($sformatf("async valid_o[%0d]", i), longint'(vo[i]), 0);
            chk($sformatf("async busy[%0d]", i), longint'(bz[i]), 0);
        end
        model_clear();
        @(negedge clk_i);
        compare_all();
        rst_ni = 1'b1;
        step(1, 1, 1, 8'd5, 8'd6);
        chk("post-reset res inst1", get_res(1), 30);
        chk("post-reset res inst3", get_res(3), 30);
        step(1, 0, 0, 8'd0, 8'd0);
        chk("post-reset res inst0", get_res(0), 30);
        chk("post-reset res inst2", get_res(2), 30);

        // Random framing, gaps and occasional soft clears against the model.
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3), 8'($urandom), 8'($urandom));
        end
        step(1, 0, 0, 8'd0, 8'd0);
        step(1, 0, 0, 8'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
